fir_cmag_iter: RTL and testbench

- Downstream of the re/im FIR filter pair: takes one complex filter output sample (re, im) and produces its magnitude |x| = sqrt(re² + im²) as an unsigned integer.
- This is the synthesizable replacement for the real-valued $sqrt magnitude used in the signal benches.
- Squares are computed in one registered cycle; the root is computed by a bit-serial, non-restoring integer square root, one result bit per cycle.
- Valid/ready handshake on both sides.

---
 rtl/fir_cmag_pkg.sv | 26 ++
 rtl/fir_cmag_iter_if.sv | 29 ++
 rtl/fir_isqrt_seq.sv | 79 +++++++
 rtl/fir_cmag_iter.sv | 104 ++++++++++
 tb/tb_fir_cmag_iter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_cmag_pkg.sv
//------------------------------------------------------------------------------
// fir_cmag_pkg : shared types and width helpers for the complex-magnitude block
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fir_cmag_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int sum_width(input int input_width);
    return 2 * input_width;
  endfunction

  function automatic int cnt_width(input int input_width);
    return $clog2(input_width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_cmag_iter_if.sv
//------------------------------------------------------------------------------
// fir_cmag_iter_if : sample-in / magnitude-out valid-ready bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fir_cmag_iter_if #(
  parameter int INPUT_WIDTH = 33
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [INPUT_WIDTH-1:0] in_re;
  logic signed [INPUT_WIDTH-1:0] in_im;
  logic                          out_valid;
  logic                          out_ready;
  logic        [INPUT_WIDTH-1:0] out_mag;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_mag
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_mag
  );
endinterface

`default_nettype wire

// File: rtl/fir_isqrt_seq.sv
//------------------------------------------------------------------------------
// fir_isqrt_seq : bit-serial integer square root, one root bit per clock
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_isqrt_seq
  import fir_cmag_pkg::*;
#(
  parameter int ROOT_W = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [2*ROOT_W-1:0]        i_radicand,
  output logic                       o_done,
  output logic [ROOT_W-1:0]          o_root,
  output logic [ROOT_W+1:0]          o_rem
);
  localparam int RAD_W = sum_width(ROOT_W);
  localparam int CNT_W = cnt_width(ROOT_W);
  localparam int REM_W = ROOT_W + 2;
  localparam int ACC_W = REM_W + 2;

  logic [RAD_W-1:0] r_rad;
  logic [ROOT_W-1:0] r_root;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_done;

  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_trial;
  logic [ACC_W-1:0] w_diff;
  logic             w_ge;

  // Remainder never exceeds 2*root, so truncating to REM_W bits is lossless.
  assign w_acc   = {r_rem, r_rad[RAD_W-1 -: 2]};
  assign w_trial = ACC_W'({r_root, 2'b01});
  assign w_diff  = w_acc - w_trial;
  assign w_ge    = (w_acc >= w_trial);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rad    <= '0;
      r_root   <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rad    <= i_radicand;
        r_root   <= '0;
        r_rem    <= '0;
        r_cnt    <= CNT_W'(ROOT_W - 1);
        r_active <= 1'b1;
      end else if (r_active) begin
        r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
        r_root <= {r_root[ROOT_W-2:0], w_ge};
        r_rem  <= w_ge ? REM_W'(w_diff) : REM_W'(w_acc);
        if (r_cnt == '0) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_root = r_root;
  assign o_rem  = r_rem;

endmodule

`default_nettype wire

// File: rtl/fir_cmag_iter.sv
//------------------------------------------------------------------------------
// fir_cmag_iter : |re + j*im| as an unsigned integer via squares + serial sqrt
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_cmag_iter
  import fir_cmag_pkg::*;
#(
  parameter int INPUT_WIDTH = 33,
  parameter bit ROUND       = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  fir_cmag_iter_if.slave bus,
  output logic           busy
);
  localparam int W     = INPUT_WIDTH;
  localparam int SUM_W = sum_width(INPUT_WIDTH);
  localparam int REM_W = INPUT_WIDTH + 2;

  state_e           r_state;
  state_e           w_next;
  logic [W-1:0]     r_abs_re;
  logic [W-1:0]     r_abs_im;
  logic [W-1:0]     r_mag;
  logic [W-1:0]     w_abs_re;
  logic [W-1:0]     w_abs_im;
  logic [W-1:0]     w_root;
  logic [REM_W-1:0] w_rem;
  logic [SUM_W-1:0] w_sum;
  logic             w_accept;
  logic             w_start;
  logic             w_done;
  logic             w_round_up;

  // Two's-complement negate in W bits maps -2^(W-1) onto 2^(W-1) unsigned.
  assign w_abs_re = bus.in_re[W-1] ? (~bus.in_re + W'(1)) : bus.in_re;
  assign w_abs_im = bus.in_im[W-1] ? (~bus.in_im + W'(1)) : bus.in_im;
  assign w_accept = bus.in_ready & bus.in_valid;
  assign w_sum    = SUM_W'(r_abs_re) * SUM_W'(r_abs_re)
                  + SUM_W'(r_abs_im) * SUM_W'(r_abs_im);
  assign w_start  = (r_state == SQUARE);
  // Rounds up exactly when sqrt(N) >= root + 0.5, i.e. remainder > root.
  assign w_round_up = ROUND && (w_rem > REM_W'(w_root));

  fir_isqrt_seq #(
    .ROOT_W (W)
  ) u_isqrt (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_radicand (w_sum),
    .o_done     (w_done),
    .o_root     (w_root),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = SQUARE;
      SQUARE:  w_next = ROOT;
      ROOT:    if (w_done) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = bus.in_valid ? SQUARE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    bus.out_valid = (r_state == DONE);
    busy          = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_abs_re <= '0;
      r_abs_im <= '0;
      r_mag    <= '0;
    end else begin
      if (w_accept) begin
        r_abs_re <= w_abs_re;
        r_abs_im <= w_abs_im;
      end
      if ((r_state == ROOT) && w_done) begin
        r_mag <= w_root + W'(w_round_up);
      end
    end
  end

  assign bus.out_mag = r_mag;

endmodule

`default_nettype wire

// File: tb/tb_fir_cmag_iter.sv
//------------------------------------------------------------------------------
// tb_fir_cmag_iter : scoreboard bench for floor (ROUND=0) and rounded (ROUND=1) builds
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_cmag_iter;
  localparam int W = 33;

  typedef struct {
    logic [W-1:0] fl;
    logic [W-1:0] rn;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                out_ready = 1'b1;
  logic                busy0;
  logic                busy1;
  logic                done_flag = 1'b0;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  int   lat;

  fir_cmag_iter_if #(.INPUT_WIDTH(W)) u_if0 ();
  fir_cmag_iter_if #(.INPUT_WIDTH(W)) u_if1 ();

  assign u_if0.in_valid  = in_valid;
  assign u_if0.in_re     = in_re;
  assign u_if0.in_im     = in_im;
  assign u_if0.out_ready = out_ready;
  assign u_if1.in_valid  = in_valid;
  assign u_if1.in_re     = in_re;
  assign u_if1.in_im     = in_im;
  assign u_if1.out_ready = out_ready;

  fir_cmag_iter #(.INPUT_WIDTH(W), .ROUND(1'b0)) u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .bus  (u_if0.slave),
    .busy (busy0)
  );

  fir_cmag_iter #(.INPUT_WIDTH(W), .ROUND(1'b1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (u_if1.slave),
    .busy (busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] isqrt(input logic [65:0] n);
    logic [W-1:0] r;
    logic [W-1:0] t;
    r = '0;
    for (int b = W - 1; b >= 0; b--) begin
      t = r | (W'(1) << b);
      if ({33'd0, t} * {33'd0, t} <= n) r = t;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    logic signed [65:0] a;
    logic signed [65:0] b;
    logic [65:0]        n;
    logic [65:0]        rem;
    exp_t               e;
    a    = re;
    b    = im;
    n    = a * a + b * b;
    e.fl = isqrt(n);
    rem  = n - {33'd0, e.fl} * {33'd0, e.fl};
    e.rn = (rem > {33'd0, e.fl}) ? e.fl + W'(1) : e.fl;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im,
                      input logic [W-1:0] fl, input logic [W-1:0] rn, input bit use_model);
    exp_t e;
    bit   ok;
    in_re    = re;
    in_im    = im;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (u_if0.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk);
    if (use_model) e = model(re, im);
    else begin
      e.fl = fl;
      e.rn = rn;
    end
    sb_q.push_back(e);
    n_in++;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (u_if0.out_valid) break;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !busy0) break;
    end
    chk("drain_queue", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && u_if0.out_valid && out_ready) begin
      exp_t e;
      chk("result_expected", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mag_floor", u_if0.out_mag, e.fl);
        chk("mag_round", u_if1.out_mag, e.rn);
        chk("valid_round_inst", u_if1.out_valid, 1);
        n_out++;
      end
    end
  end

  initial begin
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", u_if0.out_valid, 0);
    chk("rst_out_mag", u_if0.out_mag, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_in_ready", u_if0.in_ready, 1);
    chk("rst_out_mag_r", u_if1.out_mag, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Latency and single-cycle valid with out_ready held high.
    send(3, 4, 5, 5, 0);
    wait_valid(lat);
    chk("latency_3_4", lat, 35);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", u_if0.out_valid, 0);

    // Directed corner values, issued back to back.
    send(0, 0, 0, 0, 0);
    send(1, 2, 2, 2, 0);
    send(2, 3, 3, 4, 0);
    send(-33'sd4294967296, -33'sd4294967296, 33'd6074000999, 33'd6074001000, 0);
    send(-33'sd3, 33'sd4294967295, 33'd4294967295, 33'd4294967295, 0);
    wait_drain();

    // Backpressure with the next sample already waiting.
    out_ready = 1'b0;
    send(5, 12, 13, 13, 0);
    in_re    = 8;
    in_im    = -15;
    in_valid = 1'b1;
    wait_valid(lat);
    chk("latency_bp", lat, 35);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_mag_hold", u_if0.out_mag, 13);
      chk("bp_valid_hold", u_if0.out_valid, 1);
      chk("bp_in_ready", u_if0.in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", u_if0.in_ready, 1);
    @(posedge clk);
    sb_q.push_back('{fl: 17, rn: 17});
    n_in++;
    #1;
    in_valid = 1'b0;
    in_re    = 0;
    chk("bp_next_busy", busy0, 1);
    chk("bp_valid_drop", u_if0.out_valid, 0);
    wait_drain();

    // Random stream against random consumer stalls.
    done_flag = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          if (i % 3 == 0) begin
            re = W'($urandom_range(0, 2000)) - W'(1000);
            im = W'($urandom_range(0, 2000)) - W'(1000);
          end else begin
            re = {1'($urandom_range(0, 1)), $urandom};
            im = {1'($urandom_range(0, 1)), $urandom};
          end
          send(re, im, 0, 0, 1);
        end
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("stream_count", n_out, n_in);

    // Asynchronous reset in the middle of the root iterations.
    send(7, 24, 25, 25, 0);
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", u_if0.out_valid, 0);
    chk("midrst_out_mag", u_if0.out_mag, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_busy_r", busy1, 0);
    chk("midrst_out_mag_r", u_if1.out_mag, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_spurious", u_if0.out_valid, 0);
    send(6, 8, 10, 10, 0);
    wait_valid(lat);
    chk("latency_after_rst", lat, 35);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
